// File: rtl/tx_pkg.sv
// Shared types and constants for the fs/4 transmit burst generator:
// FSM states, phase codes and the carrier sign table.
package tx_pkg;

  localparam int DWIDTH_DEF   = 14;
  localparam int UNR_DEF      = 4;
  localparam int CNTWIDTH_DEF = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DELAY = 2'd1,
    ST_BURST = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam logic [1:0] PH_0   = 2'd0;
  localparam logic [1:0] PH_90  = 2'd1;
  localparam logic [1:0] PH_180 = 2'd2;
  localparam logic [1:0] PH_270 = 2'd3;

  localparam logic [1:0] CAR_ZERO = 2'd0;
  localparam logic [1:0] CAR_POS  = 2'd1;
  localparam logic [1:0] CAR_NEG  = 2'd2;

  // Entry i of one carrier period: [0, +A, 0, -A]
  localparam logic [3:0][1:0] CARRIER_TABLE = {CAR_NEG, CAR_ZERO, CAR_POS, CAR_ZERO};

  function automatic logic [1:0] carrier_code(input logic [1:0] idx);
    return CARRIER_TABLE[idx];
  endfunction

endpackage

// File: rtl/tx_carrier_lanes.sv
// Combinational mapping of amplitude/phase to one fs/4 carrier period,
// lane 0 earliest; all lanes zero when disabled.
module tx_carrier_lanes
  import tx_pkg::*;
#(
  parameter int DWIDTH = DWIDTH_DEF,
  parameter int UNR    = UNR_DEF
) (
  input  logic [DWIDTH-2:0]          amp,
  input  logic [1:0]                 phase,
  input  logic                       en,
  output logic [UNR-1:0][DWIDTH-1:0] lanes
);

  logic [DWIDTH-1:0] pos_s;
  logic [DWIDTH-1:0] neg_s;

  // amp has its MSB cleared, so negation cannot overflow to the most negative code
  assign pos_s = {1'b0, amp};
  assign neg_s = (~pos_s) + {{(DWIDTH-1){1'b0}}, 1'b1};

  // Select +A, -A or 0 per lane from the table indexed by (k + phase) mod 4
  always_comb begin
    lanes = {(UNR*DWIDTH){1'b0}};
    for (int k = 0; k < UNR; k++) begin
      if (en) begin
        case (carrier_code(2'(k) + phase))
          CAR_POS:  lanes[k] = pos_s;
          CAR_NEG:  lanes[k] = neg_s;
          CAR_ZERO: lanes[k] = {DWIDTH{1'b0}};
          default:  lanes[k] = {DWIDTH{1'b0}};
        endcase
      end else begin
        lanes[k] = {DWIDTH{1'b0}};
      end
    end
  end

endmodule

// File: rtl/tx_burst_gen.sv
// Gated fs/4 excitation burst generator: start/busy/done handshake with
// programmable pre-delay, length, amplitude and quadrature phase.
module tx_burst_gen
  import tx_pkg::*;
#(
  parameter int DWIDTH   = DWIDTH_DEF,
  parameter int UNR      = UNR_DEF,
  parameter int CNTWIDTH = CNTWIDTH_DEF
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic                       abort,
  input  logic [DWIDTH-2:0]          amp,
  input  logic [1:0]                 phase,
  input  logic [CNTWIDTH-1:0]        ndelay,
  input  logic [CNTWIDTH-1:0]        nburst,
  output logic [UNR-1:0][DWIDTH-1:0] dout,
  output logic                       dvalid,
  output logic                       busy,
  output logic                       done
);

  localparam logic [CNTWIDTH-1:0] CNT_ZERO = {CNTWIDTH{1'b0}};
  localparam logic [CNTWIDTH-1:0] CNT_ONE  = {{(CNTWIDTH-1){1'b0}}, 1'b1};

  state_t                     state_r, state_nx_s;
  logic [CNTWIDTH-1:0]        cnt_r, cnt_nx_s;
  logic [CNTWIDTH-1:0]        nburst_r, nburst_nx_s;
  logic [DWIDTH-2:0]          amp_r, amp_nx_s;
  logic [1:0]                 phase_r, phase_nx_s;
  logic [UNR-1:0][DWIDTH-1:0] lanes_s;

  // Outputs are registered from the next state, so the carrier is built from
  // the next-cycle latch values (the inputs themselves on the start edge).
  tx_carrier_lanes #(
    .DWIDTH (DWIDTH),
    .UNR    (UNR)
  ) u_lanes (
    .amp   (amp_nx_s),
    .phase (phase_nx_s),
    .en    (state_nx_s == ST_BURST),
    .lanes (lanes_s)
  );

  // Next-state, counter and parameter-latch logic
  always_comb begin
    state_nx_s  = state_r;
    cnt_nx_s    = cnt_r;
    nburst_nx_s = nburst_r;
    amp_nx_s    = amp_r;
    phase_nx_s  = phase_r;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          amp_nx_s    = amp;
          phase_nx_s  = phase;
          nburst_nx_s = nburst;
          if (ndelay != CNT_ZERO) begin
            state_nx_s = ST_DELAY;
            cnt_nx_s   = ndelay;
          end else if (nburst != CNT_ZERO) begin
            state_nx_s = ST_BURST;
            cnt_nx_s   = nburst;
          end else begin
            state_nx_s = ST_DONE;
            cnt_nx_s   = CNT_ZERO;
          end
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      ST_DELAY: begin
        if (abort) begin
          state_nx_s = ST_IDLE;
        end else if (cnt_r == CNT_ONE) begin
          if (nburst_r != CNT_ZERO) begin
            state_nx_s = ST_BURST;
            cnt_nx_s   = nburst_r;
          end else begin
            state_nx_s = ST_DONE;
            cnt_nx_s   = CNT_ZERO;
          end
        end else begin
          cnt_nx_s = cnt_r - CNT_ONE;
        end
      end
      ST_BURST: begin
        if (abort) begin
          state_nx_s = ST_IDLE;
        end else if (cnt_r == CNT_ONE) begin
          state_nx_s = ST_DONE;
          cnt_nx_s   = CNT_ZERO;
        end else begin
          cnt_nx_s = cnt_r - CNT_ONE;
        end
      end
      ST_DONE: begin
        state_nx_s = ST_IDLE;
      end
      default: begin
        state_nx_s = ST_IDLE;
      end
    endcase
  end

  // State, latches and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r  <= ST_IDLE;
      cnt_r    <= CNT_ZERO;
      nburst_r <= CNT_ZERO;
      amp_r    <= {(DWIDTH-1){1'b0}};
      phase_r  <= 2'd0;
      dout     <= {(UNR*DWIDTH){1'b0}};
      dvalid   <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state_r  <= state_nx_s;
      cnt_r    <= cnt_nx_s;
      nburst_r <= nburst_nx_s;
      amp_r    <= amp_nx_s;
      phase_r  <= phase_nx_s;
      dout     <= lanes_s;
      dvalid   <= (state_nx_s == ST_BURST);
      busy     <= (state_nx_s != ST_IDLE);
      done     <= (state_nx_s == ST_DONE);
    end
  end

endmodule

// File: tb/tb_tx_burst_gen.sv
// Self-checking bench for tx_burst_gen: a window-based burst model checked
// every cycle, plus hand-computed literal checks from the directed vectors.
module tb_tx_burst_gen;

  localparam int DW = 14;
  localparam int UN = 4;
  localparam int CW = 16;

  logic                clk = 1'b0;
  logic                reset = 1'b1;
  logic                start = 1'b0;
  logic                abort = 1'b0;
  logic [DW-2:0]       amp = '0;
  logic [1:0]          phase = '0;
  logic [CW-1:0]       ndelay = '0;
  logic [CW-1:0]       nburst = '0;
  logic [UN-1:0][DW-1:0] dout;
  logic                dvalid, busy, done;

  int tests = 0;
  int fails = 0;

  tx_burst_gen #(.DWIDTH(DW), .UNR(UN), .CNTWIDTH(CW)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .amp(amp), .phase(phase), .ndelay(ndelay), .nburst(nburst),
    .dout(dout), .dvalid(dvalid), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Model: an accepted burst at cycle c occupies fixed windows of cycles.
  int n = 0;
  bit m_act = 1'b0;
  bit chk_en = 1'b0;
  int m_c = 0, m_nd = 0, m_nb = 0, m_amp = 0, m_ph = 0;

  function automatic bit in_busy(int t);
    return m_act && (t >= m_c + 1) && (t <= m_c + m_nd + m_nb + 1);
  endfunction

  function automatic bit in_valid(int t);
    return m_act && (t >= m_c + 1 + m_nd) && (t <= m_c + m_nd + m_nb);
  endfunction

  function automatic bit is_done(int t);
    return m_act && (t == m_c + m_nd + m_nb + 1);
  endfunction

  function automatic int lane_val(int k);
    int idx;
    idx = (k + m_ph) % 4;
    if (idx == 1) return m_amp;
    else if (idx == 3) return -m_amp;
    else return 0;
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      m_act <= 1'b0;
    end else if (abort && in_busy(n)) begin
      m_act <= 1'b0;
    end else if (start && !in_busy(n)) begin
      m_act <= 1'b1;
      m_c   <= n;
      m_nd  <= int'(ndelay);
      m_nb  <= int'(nburst);
      m_amp <= int'(amp);
      m_ph  <= int'(phase);
    end
    n <= n + 1;
    if (reset) chk_en <= 1'b1;
  end

  always @(negedge clk) begin
    if (chk_en) begin
      bit e_b, e_v, e_d, bad;
      int e_l [UN];
      bad = 1'b0;
      e_b = in_busy(n);
      e_v = in_valid(n);
      e_d = is_done(n);
      for (int k = 0; k < UN; k++) begin
        e_l[k] = e_v ? lane_val(k) : 0;
        if (int'($signed(dout[k])) != e_l[k] || dout[k] == 14'h2000) bad = 1'b1;
      end
      if (busy !== e_b || dvalid !== e_v || done !== e_d) bad = 1'b1;
      tests++;
      if (bad) begin
        fails++;
        $display("FAIL model cyc%0d: got busy=%b dvalid=%b done=%b dout=%0d,%0d,%0d,%0d exp busy=%b dvalid=%b done=%b dout=%0d,%0d,%0d,%0d",
                 n, busy, dvalid, done, $signed(dout[0]), $signed(dout[1]), $signed(dout[2]), $signed(dout[3]),
                 e_b, e_v, e_d, e_l[0], e_l[1], e_l[2], e_l[3]);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int k);
    for (int i = 0; i < k; i++) tick();
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic do_start(input int a, input int p, input int nd, input int nb);
    amp    = 13'(a);
    phase  = 2'(p);
    ndelay = 16'(nd);
    nburst = 16'(nb);
    start  = 1'b1;
    tick();
    start  = 1'b0;
  endtask

  logic [DW-1:0] ph_exp [4][4];

  initial begin
    ph_exp[0] = '{14'h0000, 14'h1FFF, 14'h0000, 14'h2001};
    ph_exp[1] = '{14'h1FFF, 14'h0000, 14'h2001, 14'h0000};
    ph_exp[2] = '{14'h0000, 14'h2001, 14'h0000, 14'h1FFF};
    ph_exp[3] = '{14'h2001, 14'h0000, 14'h1FFF, 14'h0000};

    ticks(3);
    reset = 1'b0;
    chk("reset_dout", 32'(dout), 32'd0);
    chk("reset_ctl", {29'd0, busy, dvalid, done}, 32'd0);

    // Basic burst: ndelay=2, nburst=3
    do_start(1000, 0, 2, 3);
    chk("basic_busy_first", {31'd0, busy}, 32'd1);
    chk("basic_no_valid_in_delay", {31'd0, dvalid}, 32'd0);
    ticks(2);
    chk("basic_valid", {31'd0, dvalid}, 32'd1);
    chk("basic_lane0", 32'(dout[0]), 32'h0000);
    chk("basic_lane1", 32'(dout[1]), 32'd1000);
    chk("basic_lane3", 32'(dout[3]), 32'h3C18);
    ticks(3);
    chk("basic_done", {30'd0, busy, done}, 32'd3);
    tick();
    chk("basic_idle", {30'd0, busy, done}, 32'd0);

    // Phase sweep at full-scale amplitude
    for (int p = 0; p < 4; p++) begin
      do_start(8191, p, 0, 1);
      for (int k = 0; k < UN; k++) chk($sformatf("phase%0d_lane%0d", p, k), 32'(dout[k]), 32'(ph_exp[p][k]));
      ticks(2);
    end

    // Degenerate counts
    do_start(5, 0, 0, 0);
    chk("zero_zero", {29'd0, busy, dvalid, done}, 32'b101);
    tick();
    chk("zero_zero_after", {29'd0, busy, dvalid, done}, 32'd0);
    do_start(77, 2, 0, 1);
    chk("one_word_valid", {29'd0, busy, dvalid, done}, 32'b110);
    tick();
    chk("one_word_done", {29'd0, busy, dvalid, done}, 32'b101);
    tick();

    // Start while busy is ignored; start right after done is accepted
    do_start(300, 1, 1, 2);
    amp = 13'd5;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("busy_ignore_lane0", 32'(dout[0]), 32'd300);
    tick();
    chk("busy_ignore_lane2", 32'(dout[2]), 32'h3ED4);
    tick();
    chk("busy_done", {31'd0, done}, 32'd1);
    tick();
    do_start(200, 0, 0, 1);
    chk("after_done_accept", 32'(dout[1]), 32'd200);
    ticks(2);

    // Abort after the 4th valid word
    do_start(123, 0, 0, 10);
    ticks(3);
    chk("abort_4th_valid", {31'd0, dvalid}, 32'd1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_zero", {29'd0, busy, dvalid, done}, 32'd0);
    chk("abort_dout", 32'(dout[1]), 32'd0);
    ticks(8);

    // Start and abort together in IDLE: start wins
    amp = 13'd50; phase = 2'd3; ndelay = 16'd1; nburst = 16'd1;
    start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    chk("start_abort_busy", {31'd0, busy}, 32'd1);
    tick();
    chk("start_abort_lane0", 32'(dout[0]), 32'h3FCE);
    tick();
    chk("start_abort_done", {31'd0, done}, 32'd1);
    tick();

    // Mid-burst reset, then a fresh burst
    do_start(400, 1, 0, 5);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("midreset_zero", {29'd0, busy, dvalid, done}, 32'd0);
    chk("midreset_dout", 32'(dout), 32'd0);
    tick();
    do_start(600, 2, 1, 2);
    tick();
    chk("fresh_lane1", 32'(dout[1]), 32'h3DA8);
    ticks(2);
    chk("fresh_done", {31'd0, done}, 32'd1);
    ticks(3);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
